mem_access_master: RTL and testbench
====================================

Name: mem_access_master

Overview:
Initiator side of the data-memory interface. Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake. Converts the byte address to a word index and drives the memory's addr/write_data/mem_read/mem_write pins with a fixed wait-state count. Returns read data or completion to the pipeline as a one-cycle response, and exposes busy for hazard/freeze logic.

Parameters:
DATA_W, 32, data and address width (matches INSTRUCTION_LEN)
MEM_DEPTH, 2048, number of words in the target memory; word index must be < MEM_DEPTH
WAIT_CYCLES, 1, extra cycles mem strobes/address are held before completion (0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  in  1  pipeline request present
req_ready  out  1  master can accept a request (IDLE only)
req_write  in  1  1=store, 0=load
req_addr  in  DATA_W  byte address
req_wdata  in  DATA_W  store data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load data (0 for stores/errors)
resp_err  out  1  misaligned or out-of-range request, qualified by resp_valid
busy  out  1  request in flight (ACCESS or RESP)
mem_addr  out  DATA_W  word index to memory
mem_write_data  out  DATA_W  write data to memory
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_read_data  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, all outputs 0 except req_ready=1; latched request registers cleared.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On posedge with req_valid=1, latch req_write, req_addr, req_wdata. Compute word index = req_addr >> 2.
  - If req_addr[1:0]!=0 or word index >= MEM_DEPTH, go to RESP with err=1; no memory strobe is ever asserted.
  - Otherwise go to ACCESS with counter=WAIT_CYCLES.
- ACCESS: mem_addr=latched word index, mem_write_data=latched wdata, both stable for the whole state.
  - Load: mem_read=1 every ACCESS cycle. Store: mem_write=1 only in the first ACCESS cycle, so memory sees exactly one write edge.
  - Counter decrements each cycle. When counter==0, the load captures mem_read_data into resp_rdata and the state moves to RESP.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- RESP: resp_valid=1 for exactly one cycle; resp_err per latch; resp_rdata holds load data, else 0. mem_read=mem_write=0, mem_addr=0. Next state IDLE.
- Outside ACCESS: mem_read=mem_write=0, mem_addr=0, mem_write_data=0. mem_read and mem_write are never both 1.
- Latency: request accepted at edge N produces resp_valid during cycle N+WAIT_CYCLES+2. Error requests produce resp_valid in cycle N+1.
- Back-to-back: req_ready=0 during ACCESS/RESP. A new request is accepted in the cycle after RESP, so throughput is 1 request per WAIT_CYCLES+3 cycles.
- req_valid while req_ready=0 is ignored (not queued). Requester must hold req_valid until a cycle where req_ready=1.
- resp_rdata is held until the next RESP; resp_valid qualifies it.
- busy = (state!=IDLE).
- Reset mid-ACCESS aborts immediately: strobes drop asynchronously and no resp_valid is issued. A store already past its first ACCESS edge has committed.

Test Plan:
- Memory model preloaded with word0=0x00220000, WAIT_CYCLES=1; reset released; load addr 0x0 -> mem_read high 2 cycles with mem_addr=0; resp_valid one cycle at N+3, resp_rdata=0x00220000, resp_err=0.
- Store 0xDEADBEEF to 0x0000001C, then load 0x1C -> mem_write high exactly 1 cycle with mem_addr=7; load returns 0xDEADBEEF.
- Load addr 0x00000006 -> no mem_read/mem_write ever; resp_valid at N+1 with resp_err=1, resp_rdata=0. Load addr 0x2000 (word 2048) -> same error response.
- req_valid held high continuously with alternating store/load -> req_ready low during ACCESS/RESP, one accept per 4 cycles, no dropped or duplicated memory strobes.
- WAIT_CYCLES=0 -> load response at N+2; WAIT_CYCLES=3 -> N+5, with mem_addr stable across all ACCESS cycles.
- Assert rst=0 in the middle of a WAIT_CYCLES=3 load -> mem_read falls without waiting for a clock edge, no resp_valid, req_ready=1; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_access_master.sv
// -----------------------------------------------------------------------------
// mem_access_master
//   Initiator side of the data-memory interface. Takes one load/store at a time
//   from the MEM stage (valid/ready), turns the byte address into a word index,
//   holds the memory pins for WAIT_CYCLES+1 cycles, then returns a one-cycle
//   response pulse. Misaligned or out-of-range requests skip memory entirely
//   and answer with resp_err on the next cycle.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_write           1=store, 0=load
//   req_addr/req_wdata  byte address, store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load data (0 for stores/errors), held until next resp
//   resp_err            misaligned/out-of-range, qualified by resp_valid
//   busy                request in flight (ACCESS or RESP)
//   mem_addr            word index to memory (0 outside ACCESS)
//   mem_write_data      store data to memory (0 outside ACCESS)
//   mem_read/mem_write  memory strobes, never both high
//   mem_read_data       combinational read data from memory
// -----------------------------------------------------------------------------
module mem_access_master #(
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 2048,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic              err;
        logic [DATA_W-1:0] widx;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              first_q;   // high only during the first ACCESS cycle
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] widx_in;
    logic              bad_in;
    logic              last;

    assign widx_in = {2'b00, req_addr[DATA_W-1:2]};
    assign bad_in  = (|req_addr[1:0]) || (widx_in >= DATA_W'(MEM_DEPTH));
    assign last    = (cnt_q == '0);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = bad_in ? RESP : ACCESS;
            ACCESS:  if (last)      state_d = RESP;
            RESP:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // outputs: all decoded from registered state so an async reset drops the
    // strobes immediately, without waiting for a clock edge
    always_comb begin
        req_ready      = 1'b0;
        busy           = 1'b1;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ACCESS: begin
                mem_addr       = req_q.widx;
                mem_write_data = req_q.wdata;
                mem_read       = !req_q.write;
                // single write edge: the store commits on the first ACCESS edge
                mem_write      = req_q.write && first_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = req_q.err;
            end
            default: busy = 1'b0;
        endcase
    end

    assign resp_rdata = rdata_q;

    // request latch, wait counter and response data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q   <= '{write: req_write, err: bad_in,
                                     widx: widx_in, wdata: req_wdata};
                        cnt_q   <= bad_in ? '0 : WAIT_INIT;
                        first_q <= !bad_in;
                        // error responses go straight to RESP with zero data
                        if (bad_in) rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (last) rdata_q <= req_q.write ? '0 : mem_read_data;
                    else      cnt_q   <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;

    localparam int NI = 3;  // inst 0: WAIT=1, inst 1: WAIT=0, inst 2: WAIT=3

    logic        clk = 1'b0;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];
    logic        busy       [NI];
    logic [31:0] mem_addr   [NI];
    logic [31:0] mem_wdata  [NI];
    logic        mem_read   [NI];
    logic        mem_write  [NI];
    logic [31:0] mem_rdata  [NI];

    int n_chk  = 0;
    int n_fail = 0;
    int both_hi = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_access_master #(
            .DATA_W(32), .MEM_DEPTH(2048),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write[g]), .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g]), .busy(busy[g]),
            .mem_addr(mem_addr[g]), .mem_write_data(mem_wdata[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_read_data(mem_rdata[g])
        );

        logic [31:0] m [64];
        initial begin
            for (int j = 0; j < 64; j++) m[j] <= '0;
            m[0] <= 32'h0022_0000;
            m[5] <= 32'hA5A5_5A5A;
        end
        always @(posedge clk) if (mem_write[g]) m[mem_addr[g][5:0]] <= mem_wdata[g];
        assign mem_rdata[g] = m[mem_addr[g][5:0]];
    end

    always @(negedge clk)
        for (int i = 0; i < NI; i++)
            if (mem_read[i] && mem_write[i]) both_hi++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request on instance i; lat is the cycle (relative to the
    // accept edge) in which resp_valid was seen, -1 if never within budget.
    task automatic do_req(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic er,
                          output int nrd, output int nwr,
                          output logic [31:0] saddr, output logic stable,
                          output logic pulse_ok);
        logic seen;
        lat = -1; rd = '0; er = 1'b0; nrd = 0; nwr = 0;
        saddr = '0; stable = 1'b1; pulse_ok = 1'b0; seen = 1'b0;
        @(negedge clk);
        req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
        @(negedge clk);
        req_valid[i] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_read[i])  nrd++;
            if (mem_write[i]) nwr++;
            if (busy[i] && !resp_valid[i]) begin
                if (!seen) begin saddr = mem_addr[i]; seen = 1'b1; end
                else if (mem_addr[i] !== saddr) stable = 1'b0;
            end
            if (resp_valid[i]) begin
                lat = k; rd = resp_rdata[i]; er = resp_err[i];
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            pulse_ok = !resp_valid[i] && req_ready[i];
        end
    endtask

    int          lat, nrd, nwr;
    logic [31:0] rd, sa;
    logic        er, st, po;

    initial begin
        int          acc [$];
        logic [31:0] rq  [$];
        int          lowc, nr, nw, op, rcnt;

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_busy",  32'(busy[0]), 32'd0);
        chk("rst_rvld",  32'(resp_valid[0]), 32'd0);
        chk("rst_strobe", 32'({mem_read[0], mem_write[0]}), 32'd0);
        chk("rst_maddr", mem_addr[0], 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;

        // basic load, WAIT=1
        do_req(0, 1'b0, 32'h0, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("ld0_lat", 32'(lat), 32'd3);
        chk("ld0_nrd", 32'(nrd), 32'd2);
        chk("ld0_nwr", 32'(nwr), 32'd0);
        chk("ld0_addr", sa, 32'd0);
        chk("ld0_data", rd, 32'h0022_0000);
        chk("ld0_err", 32'(er), 32'd0);
        chk("ld0_pulse", 32'(po), 32'd1);

        // store then load word 7
        do_req(0, 1'b1, 32'h1C, 32'hDEAD_BEEF, lat, rd, er, nrd, nwr, sa, st, po);
        chk("st7_lat", 32'(lat), 32'd3);
        chk("st7_nwr", 32'(nwr), 32'd1);
        chk("st7_nrd", 32'(nrd), 32'd0);
        chk("st7_addr", sa, 32'd7);
        chk("st7_data", rd, 32'd0);
        do_req(0, 1'b0, 32'h1C, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("ld7_data", rd, 32'hDEAD_BEEF);
        chk("ld7_err", 32'(er), 32'd0);

        // misaligned and out-of-range
        do_req(0, 1'b0, 32'h6, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_data", rd, 32'd0);
        chk("mis_strobes", 32'(nrd + nwr), 32'd0);
        do_req(0, 1'b0, 32'h2000, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_data", rd, 32'd0);
        chk("oor_strobes", 32'(nrd + nwr), 32'd0);

        // back-to-back, req_valid held high, store/load alternating
        lowc = 0; nr = 0; nw = 0; op = 0;
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid[0]) rq.push_back(resp_rdata[0]);
            if (mem_read[0])  nr++;
            if (mem_write[0]) nw++;
            if (!req_ready[0]) lowc++;
            else if (op < 4) begin
                req_valid[0] = 1'b1;
                req_write[0] = (op % 2 == 0);
                req_addr[0]  = (op < 2) ? 32'h40 : 32'h44;
                req_wdata[0] = (op < 2) ? 32'h1111_1111 : 32'h2222_2222;
                acc.push_back(c);
                op++;
            end else req_valid[0] = 1'b0;
        end
        req_valid[0] = 1'b0;
        chk("b2b_accepts", 32'(acc.size()), 32'd4);
        for (int k = 0; k < acc.size(); k++) chk("b2b_accept_cyc", 32'(acc[k]), 32'(4 * k));
        chk("b2b_nresp", 32'(rq.size()), 32'd4);
        if (rq.size() == 4) begin
            chk("b2b_r0", rq[0], 32'd0);
            chk("b2b_r1", rq[1], 32'h1111_1111);
            chk("b2b_r2", rq[2], 32'd0);
            chk("b2b_r3", rq[3], 32'h2222_2222);
        end
        chk("b2b_ready_low", 32'(lowc), 32'd12);
        chk("b2b_nrd", 32'(nr), 32'd4);
        chk("b2b_nwr", 32'(nw), 32'd2);

        // WAIT=0
        do_req(1, 1'b0, 32'h0, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("w0_lat", 32'(lat), 32'd2);
        chk("w0_nrd", 32'(nrd), 32'd1);
        chk("w0_data", rd, 32'h0022_0000);

        // WAIT=3
        do_req(2, 1'b0, 32'h14, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("w3_lat", 32'(lat), 32'd5);
        chk("w3_nrd", 32'(nrd), 32'd4);
        chk("w3_addr", sa, 32'd5);
        chk("w3_stable", 32'(st), 32'd1);
        chk("w3_data", rd, 32'hA5A5_5A5A);

        // async reset in the middle of a WAIT=3 load
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h14;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("ar_rd_before", 32'(mem_read[2]), 32'd1);
        #1 rst[2] = 1'b0;
        #1;
        chk("ar_rd_drop", 32'(mem_read[2]), 32'd0);
        chk("ar_ready", 32'(req_ready[2]), 32'd1);
        chk("ar_busy", 32'(busy[2]), 32'd0);
        chk("ar_maddr", mem_addr[2], 32'd0);
        rcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid[2]) rcnt++;
        end
        rst[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid[2]) rcnt++;
        end
        chk("ar_no_resp", 32'(rcnt), 32'd0);
        do_req(2, 1'b0, 32'h14, 32'h0, lat, rd, er, nrd, nwr, sa, st, po);
        chk("ar_after_lat", 32'(lat), 32'd5);
        chk("ar_after_data", rd, 32'hA5A5_5A5A);

        chk("never_both_strobes", 32'(both_hi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
